// File: rtl/risc8_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc8_bus_pkg
// Description : Shared encodings for the risc8 bus responder
// Revision    : 1.0 - initial release
// ============================================================================
package risc8_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] CSR_MASK = 2'd0;
    localparam logic [1:0] CSR_PEND = 2'd1;
    localparam logic [1:0] CSR_CTRL = 2'd2;
    localparam logic [1:0] CSR_ID   = 2'd3;

    localparam logic [7:0] ID_VALUE    = 8'hA5;
    localparam logic [7:0] UNMAPPED_RD = 8'hFF;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_CSR  = 2'd1,
        RGN_IACK = 2'd2,
        RGN_NONE = 2'd3
    } region_t;

endpackage
`default_nettype wire

// File: rtl/risc8_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : risc8_irq_ctrl
// Description : 8-source edge-triggered interrupt controller with ack clear
// Revision    : 1.0 - initial release
// ============================================================================
module risc8_irq_ctrl
    import risc8_bus_pkg::*;
#(
    parameter logic [4:0] VEC_BASE = 5'b00010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic [7:0] pend_clr,
    input  logic       ack,
    output logic [7:0] mask,
    output logic [7:0] pend,
    output logic       intr,
    output logic [7:0] vector
);

    logic [7:0] r_irq_q;
    logic [7:0] r_mask;
    logic [7:0] r_pend;
    logic       r_int;

    logic [7:0] w_active;
    logic [7:0] w_rise;
    logic [7:0] w_ack_clr;
    logic [2:0] w_idx;
    logic       w_any;

    // Ascending scan: the last (highest) active bit wins
    always_comb begin
        w_active = r_pend & r_mask;
        w_any    = |w_active;
        w_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_active[i]) w_idx = i[2:0];
        end
    end

    assign w_rise    = irq & ~r_irq_q;
    assign w_ack_clr = (ack && w_any) ? (8'b1 << w_idx) : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q <= 8'h00;
            r_mask  <= 8'h00;
            r_pend  <= 8'h00;
            r_int   <= 1'b0;
        end else begin
            r_irq_q <= irq;
            r_int   <= w_any;
            // A fresh edge overrides a same-cycle clear of that bit
            r_pend  <= (r_pend & ~(pend_clr | w_ack_clr)) | w_rise;
            if (mask_we) r_mask <= mask_wdata;
        end
    end

    assign mask   = r_mask;
    assign pend   = r_pend;
    assign intr   = r_int;
    assign vector = w_any ? {VEC_BASE, w_idx} : UNMAPPED_RD;

endmodule
`default_nettype wire

// File: rtl/risc8_bus_resp.sv
`default_nettype none
// ============================================================================
// Module      : risc8_bus_resp
// Description : Bus target for the risc8 core: scratch RAM, CSR page, IRQ ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module risc8_bus_resp
    import risc8_bus_pkg::*;
#(
    parameter int          RAM_AW   = 6,
    parameter logic [15:0] RAM_BASE = 16'h0000,
    parameter logic [15:0] CSR_BASE = 16'hFF00,
    parameter logic [1:0]  WAIT_RST = 2'd1,
    parameter int          TIMEOUT  = 8,
    parameter logic [4:0]  VEC_BASE = 5'b00010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cycle,
    input  logic        write,
    input  logic        ifetch,
    input  logic        iack,
    input  logic [15:0] address,
    input  logic [7:0]  data_out,
    output logic [7:0]  data_in,
    output logic        ready,
    output logic        intr,
    input  logic [7:0]  irq,
    output logic        bus_err
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_load_cnt;
    region_t           r_rgn;
    region_t           w_rgn;
    logic [RAM_AW-1:0] r_addr;
    logic              r_write;
    logic [7:0]        r_wdata;
    logic [1:0]        r_wait;
    logic [7:0]        r_mem [2**RAM_AW];

    logic [7:0] w_rdata;
    logic       w_commit;
    logic       w_csr_we;
    logic [7:0] irq_mask;
    logic [7:0] irq_pend;
    logic [7:0] irq_vector;

    always_comb begin
        if (iack)                                          w_rgn = RGN_IACK;
        else if (address[15:2] == CSR_BASE[15:2])          w_rgn = RGN_CSR;
        else if (address[15:RAM_AW] == RAM_BASE[15:RAM_AW]) w_rgn = RGN_RAM;
        else                                               w_rgn = RGN_NONE;
    end

    assign w_load_cnt = (w_rgn == RGN_NONE) ? CNT_W'(TIMEOUT - 1) : CNT_W'(r_wait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // cnt holds the remaining wait clocks; leaving WAIT on 1 lands RESP at n+1+WAIT
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (cycle) w_next = (w_load_cnt == '0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (!cycle)                w_next = ST_IDLE;
                else if (r_cnt <= CNT_ONE) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready   = (r_state == ST_RESP);
        bus_err = ready && (r_rgn == RGN_NONE);
        data_in = ready ? w_rdata : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_rgn   <= RGN_RAM;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= 8'h00;
        end else if (r_state == ST_IDLE && cycle) begin
            r_cnt   <= w_load_cnt;
            r_rgn   <= w_rgn;
            r_addr  <= address[RAM_AW-1:0];
            r_write <= write && !ifetch && !iack;
            r_wdata <= data_out;
        end else if (r_state == ST_WAIT && r_cnt != '0) begin
            r_cnt   <= r_cnt - CNT_ONE;
        end
    end

    assign w_commit = (r_state == ST_RESP) && r_write;
    assign w_csr_we = w_commit && (r_rgn == RGN_CSR);

    always_ff @(posedge clk) begin
        if (w_commit && r_rgn == RGN_RAM) r_mem[r_addr] <= r_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_wait <= WAIT_RST;
        else if (w_csr_we && r_addr[1:0] == CSR_CTRL) r_wait <= r_wdata[1:0];
    end

    always_comb begin
        w_rdata = UNMAPPED_RD;
        case (r_rgn)
            RGN_RAM:  w_rdata = r_mem[r_addr];
            RGN_IACK: w_rdata = irq_vector;
            RGN_CSR: begin
                case (r_addr[1:0])
                    CSR_MASK: w_rdata = irq_mask;
                    CSR_PEND: w_rdata = irq_pend;
                    CSR_CTRL: w_rdata = {6'b000000, r_wait};
                    default:  w_rdata = ID_VALUE;
                endcase
            end
            default:  w_rdata = UNMAPPED_RD;
        endcase
    end

    risc8_irq_ctrl #(
        .VEC_BASE (VEC_BASE)
    ) u_irq_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .mask_we    (w_csr_we && r_addr[1:0] == CSR_MASK),
        .mask_wdata (r_wdata),
        .pend_clr   ((w_csr_we && r_addr[1:0] == CSR_PEND) ? r_wdata : 8'h00),
        .ack        ((r_state == ST_RESP) && (r_rgn == RGN_IACK)),
        .mask       (irq_mask),
        .pend       (irq_pend),
        .intr       (intr),
        .vector     (irq_vector)
    );

endmodule
`default_nettype wire

// File: tb/tb_risc8_bus_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc8_bus_resp
// Description : Directed plus random bench for risc8_bus_resp with a memory/IRQ model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc8_bus_resp;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cycle = 1'b0;
    logic        write = 1'b0;
    logic        ifetch = 1'b0;
    logic        iack = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic [7:0]  data_in;
    logic        ready;
    logic        intr;
    logic [7:0]  irq = 8'h00;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_mem [64];
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_pend = 8'h00;
    logic [1:0] m_wait = 2'd1;

    risc8_bus_resp #(
        .RAM_AW   (6),
        .RAM_BASE (16'h0000),
        .CSR_BASE (16'hFF00),
        .WAIT_RST (2'd1),
        .TIMEOUT  (TIMEOUT),
        .VEC_BASE (5'b00010)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cycle    (cycle),
        .write    (write),
        .ifetch   (ifetch),
        .iack     (iack),
        .address  (address),
        .data_out (data_out),
        .data_in  (data_in),
        .ready    (ready),
        .intr     (intr),
        .irq      (irq),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 0=RAM 1=CSR 2=iack 3=unmapped
    function automatic int region(input logic ia, input logic [15:0] a);
        if (ia) return 2;
        if (a[15:2] == 14'h3FC0) return 1;
        if (a[15:6] == 10'd0) return 0;
        return 3;
    endfunction

    function automatic int top_idx(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] exp_rd(input int r, input logic [15:0] a);
        int idx;
        logic [2:0] s;
        case (r)
            0: return m_mem[a[5:0]];
            1: case (a[1:0])
                   2'd0:    return m_mask;
                   2'd1:    return m_pend;
                   2'd2:    return {6'd0, m_wait};
                   default: return 8'hA5;
               endcase
            2: begin
                idx = top_idx(m_pend & m_mask);
                if (idx < 0) return 8'hFF;
                s = idx[2:0];
                return {5'b00010, s};
            end
            default: return 8'hFF;
        endcase
    endfunction

    task automatic txn(input logic w, input logic ia, input logic [15:0] a,
                       input logic [7:0] d, input logic fetch);
        int r, lat, n, idx;
        logic [7:0] e;
        logic rd;
        r   = region(ia, a);
        lat = (r == 3) ? TIMEOUT : 1 + int'(m_wait);
        e   = exp_rd(r, a);
        rd  = !(w && !fetch && !ia);
        address = a; write = w; iack = ia; ifetch = fetch; data_out = d; cycle = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 64);
        chk("latency", n, lat);
        if (rd) chk("rdata", 32'(data_in), 32'(e));
        chk("bus_err", 32'(bus_err), 32'(r == 3));
        cycle = 1'b0; write = 1'b0; iack = 1'b0; ifetch = 1'b0;
        if (!rd && r == 0) m_mem[a[5:0]] = d;
        if (!rd && r == 1) begin
            case (a[1:0])
                2'd0:    m_mask = d;
                2'd1:    m_pend = m_pend & ~d;
                2'd2:    m_wait = d[1:0];
                default: ;
            endcase
        end
        if (r == 2) begin
            idx = top_idx(m_pend & m_mask);
            if (idx >= 0) m_pend[idx] = 1'b0;
        end
        @(posedge clk); #1;
        chk("ready_one_cycle", {23'd0, ready, data_in}, 32'd0);
        @(posedge clk); #1;
        chk("int", 32'(intr), 32'(|(m_pend & m_mask)));
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq = bits;
        m_pend = m_pend | bits;
        repeat (2) @(posedge clk);
        #1 irq = 8'h00;
        repeat (2) @(posedge clk);
        #1 chk("int_after_irq", 32'(intr), 32'(|(m_pend & m_mask)));
    endtask

    initial begin
        logic seen;
        int k;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_outputs", {21'd0, ready, bus_err, intr, data_in}, 32'd0);

        txn(1'b1, 1'b0, 16'hFF02, 8'h00, 1'b0);
        for (int i = 0; i < 64; i++) txn(1'b1, 1'b0, 16'(i), 8'($urandom), 1'b0);

        // Reset in the middle of a waited access
        txn(1'b1, 1'b0, 16'hFF02, 8'h03, 1'b0);
        txn(1'b1, 1'b0, 16'hFF00, 8'h01, 1'b0);
        pulse(8'h01);
        address = 16'h0010; write = 1'b0; cycle = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_wait", {22'd0, ready, intr, data_in}, 32'd0);
        cycle = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        m_mask = 8'h00; m_pend = 8'h00; m_wait = 2'd1;
        txn(1'b0, 1'b0, 16'hFF00, 8'h00, 1'b0);
        txn(1'b0, 1'b0, 16'hFF02, 8'h00, 1'b0);
        txn(1'b0, 1'b0, 16'hFF03, 8'h00, 1'b0);

        // RAM with zero wait, then WAIT=3
        txn(1'b1, 1'b0, 16'hFF02, 8'h00, 1'b0);
        txn(1'b1, 1'b0, 16'h0010, 8'h5A, 1'b0);
        txn(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0);
        txn(1'b1, 1'b0, 16'hFF02, 8'h03, 1'b0);
        txn(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0);

        // Unmapped
        txn(1'b0, 1'b0, 16'h8000, 8'h00, 1'b0);
        txn(1'b1, 1'b0, 16'h8000, 8'hC3, 1'b0);
        txn(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        txn(1'b0, 1'b0, 16'hFF00, 8'h00, 1'b0);

        // Interrupts and iack priority
        txn(1'b1, 1'b0, 16'hFF00, 8'h48, 1'b0);
        pulse(8'h48);
        chk("int_set", 32'(intr), 32'd1);
        txn(1'b0, 1'b1, 16'h1234, 8'h00, 1'b0);
        txn(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
        chk("int_clear", 32'(intr), 32'd0);
        txn(1'b0, 1'b1, 16'hFF01, 8'h00, 1'b0);

        // Abort during WAIT
        address = 16'h0020; write = 1'b1; data_out = 8'h77; cycle = 1'b1;
        repeat (2) @(posedge clk);
        #1 cycle = 1'b0; write = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ready;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        txn(1'b0, 1'b0, 16'h0020, 8'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1:    txn(1'b1, 1'b0, 16'($urandom_range(0, 63)), 8'($urandom), 1'b0);
                2, 3:    txn(1'b0, 1'b0, 16'($urandom_range(0, 63)), 8'h00, 1'b0);
                4:       txn(1'b0, 1'b0, 16'hFF00 | 16'($urandom_range(0, 3)), 8'h00, 1'b0);
                5:       txn(1'b1, 1'b0, 16'hFF00 | 16'($urandom_range(0, 3)), 8'($urandom), 1'b0);
                6:       txn(1'($urandom), 1'b0, 16'($urandom_range(16'h0040, 16'hFEFF)), 8'($urandom), 1'b0);
                7:       txn(1'b0, 1'b1, 16'($urandom), 8'h00, 1'b0);
                8:       pulse(8'($urandom));
                default: txn(1'b0, 1'b0, 16'($urandom_range(0, 63)), 8'h00, 1'b1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
